// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiters: FSM state encoding,
// data-memory window and the wait-counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic [31:0] DMEM_BASE = 32'h1001_0000;
    localparam logic [31:0] DMEM_SIZE = 32'h0000_1000;
    localparam int          WAIT_W    = 4;

    // Window must not cross 2^32, so a plain 32-bit compare is exact.
    function automatic logic addr_bad(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
        return (addr < base) || (addr >= base + size) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to the port that was not granted last time.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant
);

    assign grant_valid = |req;
    assign grant       = (req == 2'b11) ? ~last_grant : req[1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester front end for the single-port data memory: round-robin grant,
// window/alignment check, memory-side access timing and a one-cycle ready pulse.
module dmem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
    parameter logic [31:0] SIZE_BYTES  = DMEM_SIZE,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ready0,
    output logic        ready1,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        busy
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);
    // With no wait states the first ACCESS cycle is also the final one.
    localparam logic              NO_WAIT   = (WAIT_CYCLES == 0);

    arb_state_t        state;
    logic              last_grant;
    logic              grant_q;
    logic              we_q;
    logic              bad_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic              grant_valid;
    logic              grant;
    logic              sel_we;
    logic              sel_bad;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;

    rr_pick2 u_pick (
        .req         ({req1, req0}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    always_comb begin
        sel_we    = grant ? we1    : we0;
        sel_addr  = grant ? addr1  : addr0;
        sel_wdata = grant ? wdata1 : wdata0;
        sel_bad   = addr_bad(sel_addr, BASE_ADDR, SIZE_BYTES);
    end

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            grant_q        <= 1'b0;
            we_q           <= 1'b0;
            bad_q          <= 1'b0;
            wait_cnt       <= '0;
            ready0         <= 1'b0;
            ready1         <= 1'b0;
            rdata          <= '0;
            err            <= 1'b0;
            mem_address    <= '0;
            mem_write      <= 1'b0;
            mem_write_data <= '0;
        end else begin
            ready0 <= 1'b0;
            ready1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        grant_q        <= grant;
                        we_q           <= sel_we;
                        bad_q          <= sel_bad;
                        mem_address    <= sel_addr;
                        mem_write_data <= sel_wdata;
                        mem_write      <= NO_WAIT & sel_we & ~sel_bad;
                        wait_cnt       <= WAIT_INIT;
                        state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        mem_write <= 1'b0;
                        rdata     <= (we_q | bad_q) ? '0 : mem_read_data;
                        err       <= bad_q;
                        ready0    <= ~grant_q;
                        ready1    <= grant_q;
                        state     <= RESP;
                    end else begin
                        // Raise the write strobe for the final ACCESS cycle only.
                        if (wait_cnt == WAIT_W'(1)) begin
                            mem_write <= we_q & ~bad_q;
                        end
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                RESP: begin
                    last_grant <= grant_q;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: three instances (0, 2 and 3 wait states)
// share the requester inputs, each with its own behavioural data memory.
module tb_dmem_port_arbiter;

    localparam int          NDUT = 3;
    localparam int          D0   = 0;
    localparam int          D2   = 1;
    localparam int          D3   = 2;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [31:0] SIZE = 32'h0000_1000;

    logic        clock = 1'b0;
    logic        clear;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic        rdy0 [NDUT];
    logic        rdy1 [NDUT];
    logic [31:0] rd   [NDUT];
    logic        er   [NDUT];
    logic [31:0] maddr[NDUT];
    logic        mwr  [NDUT];
    logic [31:0] mwd  [NDUT];
    logic [31:0] mrd  [NDUT];
    logic        bsy  [NDUT];

    logic [31:0] mem [NDUT][1024];
    logic        load_en;
    logic [9:0]  load_idx;
    logic [31:0] load_data;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_port_arbiter #(
            .BASE_ADDR   (BASE),
            .SIZE_BYTES  (SIZE),
            .WAIT_CYCLES ((g == 0) ? 0 : g + 1)
        ) u_dut (
            .clock          (clock),
            .clear          (clear),
            .req0           (req0),
            .req1           (req1),
            .we0            (we0),
            .we1            (we1),
            .addr0          (addr0),
            .addr1          (addr1),
            .wdata0         (wdata0),
            .wdata1         (wdata1),
            .ready0         (rdy0[g]),
            .ready1         (rdy1[g]),
            .rdata          (rd[g]),
            .err            (er[g]),
            .mem_address    (maddr[g]),
            .mem_write      (mwr[g]),
            .mem_write_data (mwd[g]),
            .mem_read_data  (mrd[g]),
            .busy           (bsy[g])
        );
    end

    function automatic logic in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + SIZE);
    endfunction

    function automatic logic [9:0] widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[11:2];
    endfunction

    // Memory model: negedge write, combinational read, 0 outside the window.
    always @(negedge clock) begin
        for (int i = 0; i < NDUT; i++) begin
            if (load_en) mem[i][load_idx] <= load_data;
            else if (mwr[i] && in_win(maddr[i])) mem[i][widx(maddr[i])] <= mwd[i];
        end
    end

    always @* begin
        for (int i = 0; i < NDUT; i++) begin
            mrd[i] = in_win(maddr[i]) ? mem[i][widx(maddr[i])] : 32'h0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        clear = 1'b1;
        #3;
        clear = 1'b0;
        tick();
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] data);
        load_en = 1'b1; load_idx = idx; load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < NDUT; i++) begin
            checks++; if (bsy[i] !== 1'b0)   $display("FAIL reset_busy[%0d]: got %b expected 0", i, bsy[i]); else passes++;
            checks++; if (rdy0[i] !== 1'b0)  $display("FAIL reset_ready0[%0d]: got %b expected 0", i, rdy0[i]); else passes++;
            checks++; if (rdy1[i] !== 1'b0)  $display("FAIL reset_ready1[%0d]: got %b expected 0", i, rdy1[i]); else passes++;
            checks++; if (mwr[i] !== 1'b0)   $display("FAIL reset_mem_write[%0d]: got %b expected 0", i, mwr[i]); else passes++;
            checks++; if (maddr[i] !== 32'h0) $display("FAIL reset_mem_address[%0d]: got %h expected 0", i, maddr[i]); else passes++;
            checks++; if (rd[i] !== 32'h0 || er[i] !== 1'b0) $display("FAIL reset_rdata_err[%0d]: got %h/%b expected 0/0", i, rd[i], er[i]); else passes++;
        end
        clear = 1'b0;
        tick();
        tick();
        checks++; if (bsy[D0] !== 1'b0) $display("FAIL idle_no_req_busy: got %b expected 0", bsy[D0]); else passes++;
    endtask

    task automatic test_clear_mid_access();
        int rcount;
        load(10'd3, 32'h1111_1111);
        do_clear();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h1001_000C; wdata0 = 32'hCAFE_F00D;
        tick();
        checks++; if (bsy[D3] !== 1'b1) $display("FAIL clr_busy_after_grant: got %b expected 1", bsy[D3]); else passes++;
        checks++; if (mwr[D3] !== 1'b0) $display("FAIL clr_early_write: got %b expected 0", mwr[D3]); else passes++;
        tick(); tick(); tick();
        checks++; if (mwr[D3] !== 1'b1) $display("FAIL clr_write_pending: got %b expected 1", mwr[D3]); else passes++;
        clear = 1'b1;
        #1;
        checks++; if (mwr[D3] !== 1'b0) $display("FAIL clr_mem_write_drop: got %b expected 0", mwr[D3]); else passes++;
        checks++; if (bsy[D3] !== 1'b0) $display("FAIL clr_state_idle: got %b expected 0", bsy[D3]); else passes++;
        req0 = 1'b0; we0 = 1'b0;
        #2;
        clear = 1'b0;
        rcount = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rdy0[D3] === 1'b1) rcount++;
        end
        checks++; if (rcount !== 0) $display("FAIL clr_no_ready: got %0d pulses expected 0", rcount); else passes++;
        checks++; if (mem[D3][3] !== 32'h1111_1111) $display("FAIL clr_mem_unchanged: got %h expected 11111111", mem[D3][3]); else passes++;
    endtask

    task automatic test_write_read();
        int wcount;
        do_clear();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h1001_0008; wdata0 = 32'hDEAD_BEEF;
        tick();
        wcount = int'(mwr[D0]);
        checks++; if (rdy0[D0] !== 1'b0) $display("FAIL wr_ready_early: got %b expected 0", rdy0[D0]); else passes++;
        checks++; if (maddr[D0] !== 32'h1001_0008) $display("FAIL wr_mem_address: got %h expected 10010008", maddr[D0]); else passes++;
        checks++; if (mwd[D0] !== 32'hDEAD_BEEF) $display("FAIL wr_mem_write_data: got %h expected deadbeef", mwd[D0]); else passes++;
        tick();
        wcount += int'(mwr[D0]);
        checks++; if (rdy0[D0] !== 1'b1) $display("FAIL wr_ready0: got %b expected 1", rdy0[D0]); else passes++;
        checks++; if (rd[D0] !== 32'h0 || er[D0] !== 1'b0) $display("FAIL wr_rdata_err: got %h/%b expected 0/0", rd[D0], er[D0]); else passes++;
        req0 = 1'b0;
        tick();
        wcount += int'(mwr[D0]);
        checks++; if (rdy0[D0] !== 1'b0 || bsy[D0] !== 1'b0) $display("FAIL wr_back_to_idle: got ready %b busy %b expected 0 0", rdy0[D0], bsy[D0]); else passes++;
        checks++; if (wcount !== 1) $display("FAIL wr_pulse_count: got %0d expected 1", wcount); else passes++;
        checks++; if (mem[D0][2] !== 32'hDEAD_BEEF) $display("FAIL wr_mem_word: got %h expected deadbeef", mem[D0][2]); else passes++;
        req0 = 1'b1; we0 = 1'b0;
        tick();
        wcount = int'(mwr[D0]);
        tick();
        wcount += int'(mwr[D0]);
        checks++; if (rdy0[D0] !== 1'b1) $display("FAIL rd_ready0: got %b expected 1", rdy0[D0]); else passes++;
        checks++; if (rd[D0] !== 32'hDEAD_BEEF) $display("FAIL rd_rdata: got %h expected deadbeef", rd[D0]); else passes++;
        checks++; if (er[D0] !== 1'b0) $display("FAIL rd_err: got %b expected 0", er[D0]); else passes++;
        checks++; if (wcount !== 0) $display("FAIL rd_no_write: got %0d expected 0", wcount); else passes++;
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic exp_g;
        load(10'd0, 32'd100);
        load(10'd1, 32'd200);
        do_clear();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h1001_0000;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h1001_0004;
        for (int t = 0; t < 4; t++) begin
            exp_g = t[0];
            tick();
            checks++; if (rdy0[D0] !== 1'b0 || rdy1[D0] !== 1'b0) $display("FAIL rr_ready_in_access[%0d]: got %b%b expected 00", t, rdy1[D0], rdy0[D0]); else passes++;
            tick();
            checks++; if (rdy0[D0] !== !exp_g || rdy1[D0] !== exp_g) $display("FAIL rr_grant[%0d]: got ready1/0 %b%b expected port %0d", t, rdy1[D0], rdy0[D0], exp_g); else passes++;
            checks++; if (rd[D0] !== (exp_g ? 32'd200 : 32'd100)) $display("FAIL rr_rdata[%0d]: got %0d expected %0d", t, rd[D0], exp_g ? 200 : 100); else passes++;
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_dropped_req();
        int r0count;
        do_clear();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h1001_0004;
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h1001_0000;
        r0count = int'(rdy0[D0]);
        tick();
        checks++; if (rdy1[D0] !== 1'b1 || rd[D0] !== 32'd200) $display("FAIL drop_req1_served: got ready1 %b rdata %0d expected 1 200", rdy1[D0], rd[D0]); else passes++;
        r0count += int'(rdy0[D0]);
        req0 = 1'b0; req1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            r0count += int'(rdy0[D0]);
        end
        checks++; if (r0count !== 0) $display("FAIL drop_no_ready0: got %0d pulses expected 0", r0count); else passes++;
        checks++; if (bsy[D0] !== 1'b0) $display("FAIL drop_not_served: got busy %b expected 0", bsy[D0]); else passes++;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        tick();
        checks++; if (rdy0[D0] !== 1'b1 || rdy1[D0] !== 1'b0) $display("FAIL drop_next_rr: got ready1/0 %b%b expected 01", rdy1[D0], rdy0[D0]); else passes++;
        checks++; if (rd[D0] !== 32'd100) $display("FAIL drop_next_rdata: got %0d expected 100", rd[D0]); else passes++;
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_invalid_addr();
        logic [31:0] v_addr [5];
        logic        v_we   [5];
        logic        v_err  [5];
        logic [31:0] v_rd   [5];
        int          wcount;
        v_addr = '{32'h1001_1000, 32'h1001_0002, 32'h1001_0002, 32'h1000_FFFC, 32'h1001_0FFC};
        v_we   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        v_err  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        v_rd   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0BAD_F00D};
        load(10'd0, 32'hA5A5_A5A5);
        load(10'd1023, 32'h0BAD_F00D);
        do_clear();
        wcount = 0;
        for (int v = 0; v < 5; v++) begin
            req1 = 1'b1; we1 = v_we[v]; addr1 = v_addr[v]; wdata1 = 32'h1234_5678;
            tick();
            wcount += int'(mwr[D0]);
            checks++; if (maddr[D0] !== v_addr[v]) $display("FAIL inv_mem_address[%0d]: got %h expected %h", v, maddr[D0], v_addr[v]); else passes++;
            tick();
            wcount += int'(mwr[D0]);
            checks++; if (rdy1[D0] !== 1'b1 || rdy0[D0] !== 1'b0) $display("FAIL inv_ready[%0d]: got ready1/0 %b%b expected 10", v, rdy1[D0], rdy0[D0]); else passes++;
            checks++; if (er[D0] !== v_err[v]) $display("FAIL inv_err[%0d]: got %b expected %b", v, er[D0], v_err[v]); else passes++;
            checks++; if (rd[D0] !== v_rd[v]) $display("FAIL inv_rdata[%0d]: got %h expected %h", v, rd[D0], v_rd[v]); else passes++;
            req1 = 1'b0;
            tick();
            wcount += int'(mwr[D0]);
        end
        checks++; if (wcount !== 0) $display("FAIL inv_no_write: got %0d cycles expected 0", wcount); else passes++;
        checks++; if (mem[D0][0] !== 32'hA5A5_A5A5) $display("FAIL inv_mem_word0: got %h expected a5a5a5a5", mem[D0][0]); else passes++;
        checks++; if (mem[D0][1023] !== 32'h0BAD_F00D) $display("FAIL inv_mem_word1023: got %h expected 0badf00d", mem[D0][1023]); else passes++;
    endtask

    task automatic test_wait_states();
        int busy_cycles;
        int ready_cycles;
        int ready_at;
        load(10'd5, 32'h55AA_55AA);
        do_clear();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h1001_0014;
        busy_cycles  = 0;
        ready_cycles = 0;
        ready_at     = -1;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (bsy[D2] === 1'b1) busy_cycles++;
            if (rdy0[D2] === 1'b1) begin
                ready_cycles++;
                if (ready_at < 0) ready_at = c;
                checks++; if (rd[D2] !== 32'h55AA_55AA) $display("FAIL ws_rdata: got %h expected 55aa55aa", rd[D2]); else passes++;
                req0 = 1'b0;
            end
            if (c < 3) begin
                checks++; if (maddr[D2] !== 32'h1001_0014) $display("FAIL ws_mem_address[%0d]: got %h expected 10010014", c, maddr[D2]); else passes++;
            end
        end
        req0 = 1'b0;
        checks++; if (ready_at !== 3) $display("FAIL ws_ready_latency: got cycle %0d expected 3", ready_at); else passes++;
        checks++; if (ready_cycles !== 1) $display("FAIL ws_ready_width: got %0d expected 1", ready_cycles); else passes++;
        checks++; if (busy_cycles !== 4) $display("FAIL ws_busy_cycles: got %0d expected 4", busy_cycles); else passes++;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        clear = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        load_en = 1'b0; load_idx = '0; load_data = '0;
        test_reset();
        test_clear_mid_access();
        test_write_read();
        test_contention();
        test_dropped_req();
        test_invalid_addr();
        test_wait_states();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
